arf_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port address register file (ARF, one-port RAM with fixed read latency) among NUM_REQ requesters, e.g. the memory-access unit and the scalar/control unit.
- Accepts at most one access per cycle and drives the registered ARF port.
- Tracks in-flight reads through a tag pipeline matched to READ_DELAY, so each read response returns only to the requester that issued it.

---
 rtl/arf_arbiter.sv | 141 ++++++++++++++
 tb/tb_arf_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arf_arbiter.sv
// arf_arbiter: round-robin arbiter sharing the single-port address register
// file among NUM_REQ requesters. One access is accepted per cycle and drives
// the registered ARF port. In-flight reads carry the issuing requester's
// index through a tag pipeline so each response strobes only that requester.
module arf_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ARF_ADDRWIDTH = 5,
    parameter int ARF_DATAWIDTH = 36,
    parameter int READ_DELAY    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_we_i,
    input  logic [NUM_REQ*ARF_ADDRWIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*ARF_DATAWIDTH-1:0]   req_din_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [ARF_DATAWIDTH-1:0]           rsp_data_o,
    output logic                               arf_en_o,
    output logic                               arf_we_o,
    output logic [ARF_ADDRWIDTH-1:0]           arf_addr_o,
    output logic [ARF_DATAWIDTH-1:0]           arf_din_o,
    input  logic [ARF_DATAWIDTH-1:0]           arf_dout_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Arbitration state and grant decode
    logic [IDX_W-1:0]         ptr_r;
    logic [NUM_REQ-1:0]       grant_s;
    logic [IDX_W-1:0]         grant_idx_s;
    logic                     accept_s;

    // Registered ARF port and the tag of the access currently on it
    logic                     arf_en_r;
    logic                     arf_we_r;
    logic [ARF_ADDRWIDTH-1:0] arf_addr_r;
    logic [ARF_DATAWIDTH-1:0] arf_din_r;
    logic [IDX_W-1:0]         arf_tag_r;

    // Read-tracking pipeline; the extra output register lines the strobe up
    // with the cycle in which the RAM presents its data.
    logic [READ_DELAY-1:0]    pipe_vld_r;
    logic [IDX_W-1:0]         pipe_tag_r [READ_DELAY];
    logic [NUM_REQ-1:0]       rsp_valid_r;

    // Round-robin scan starting one past the last granted requester
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        grant_s     = {NUM_REQ{1'b0}};
        grant_idx_s = {IDX_W{1'b0}};
        accept_s    = 1'b0;
        cand_v      = {IDX_W{1'b0}};
        if (!rst) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand_v = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
                if (!accept_s && req_valid_i[cand_v]) begin
                    accept_s        = 1'b1;
                    grant_idx_s     = cand_v;
                    grant_s[cand_v] = 1'b1;
                end else begin
                    accept_s = accept_s;
                end
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Move the priority pointer to the winner only when an access is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= IDX_W'(NUM_REQ - 1);
        end else if (accept_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Launch the accepted access onto the ARF port; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            arf_en_r   <= 1'b0;
            arf_we_r   <= 1'b0;
            arf_addr_r <= {ARF_ADDRWIDTH{1'b0}};
            arf_din_r  <= {ARF_DATAWIDTH{1'b0}};
            arf_tag_r  <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            arf_en_r   <= 1'b1;
            arf_we_r   <= req_we_i[grant_idx_s];
            arf_addr_r <= req_addr_i[grant_idx_s*ARF_ADDRWIDTH +: ARF_ADDRWIDTH];
            arf_din_r  <= req_din_i[grant_idx_s*ARF_DATAWIDTH +: ARF_DATAWIDTH];
            arf_tag_r  <= grant_idx_s;
        end else begin
            arf_en_r   <= 1'b0;
            arf_we_r   <= 1'b0;
        end
    end

    // Shift issued reads through the tag pipeline, flushing on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r <= {READ_DELAY{1'b0}};
            for (int i = 0; i < READ_DELAY; i++) begin
                pipe_tag_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= arf_en_r & ~arf_we_r;
            pipe_tag_r[0] <= arf_tag_r;
            for (int i = 1; i < READ_DELAY; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
        end
    end

    // Decode the pipeline tail into a one-cycle strobe for the issuing requester
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
        end else begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            if (pipe_vld_r[READ_DELAY-1]) begin
                rsp_valid_r[pipe_tag_r[READ_DELAY-1]] <= 1'b1;
            end else begin
                rsp_valid_r <= {NUM_REQ{1'b0}};
            end
        end
    end

    assign req_ready_o = grant_s;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = arf_dout_i;
    assign arf_en_o    = arf_en_r;
    assign arf_we_o    = arf_we_r;
    assign arf_addr_o  = arf_addr_r;
    assign arf_din_o   = arf_din_r;

endmodule

// File: tb/tb_arf_arbiter.sv
// Testbench for arf_arbiter: directed scenarios plus randomized traffic,
// checked against a round-robin / memory reference model and a response
// scoreboard popped by an independent monitor.
module tb_arf_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 36;
    localparam int RD = 2;

    typedef struct {
        int            req;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    v;
    logic [N-1:0]    w;
    logic [AW-1:0]   a [N];
    logic [DW-1:0]   d [N];
    logic [N*AW-1:0] addr_p;
    logic [N*DW-1:0] din_p;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_data_o;
    logic            arf_en_o;
    logic            arf_we_o;
    logic [AW-1:0]   arf_addr_o;
    logic [DW-1:0]   arf_din_o;
    logic [DW-1:0]   arf_dout_i;

    // RAM model (environment) and reference model state
    logic [DW-1:0]   ram [32];
    logic [DW-1:0]   rpipe [RD+1];
    logic            ram_init;
    logic [DW-1:0]   mem [32];
    int              m_ptr;
    logic            e_en;
    logic            e_we;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_din;
    exp_t            q [$];
    int              cyc;
    int              errors;
    int              checks;
    logic            mon_en;
    int              acc;

    arf_arbiter #(
        .NUM_REQ(N), .ARF_ADDRWIDTH(AW), .ARF_DATAWIDTH(DW), .READ_DELAY(RD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(v), .req_ready_o(req_ready_o), .req_we_i(w),
        .req_addr_i(addr_p), .req_din_i(din_p),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .arf_en_o(arf_en_o), .arf_we_o(arf_we_o),
        .arf_addr_o(arf_addr_o), .arf_din_o(arf_din_o),
        .arf_dout_i(arf_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        addr_p = '0;
        din_p  = '0;
        for (int k = 0; k < N; k++) begin
            addr_p[k*AW +: AW] = a[k];
            din_p[k*DW +: DW]  = d[k];
        end
    end

    function automatic logic [DW-1:0] init_val(int i);
        if (i == 4) return 36'h0_0000_1000;
        return {4'(i), 32'hC0DE_0000 + 32'(i)};
    endfunction

    // Single-port RAM: data for a read sampled at edge E appears after edge E+RD
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (arf_en_o && arf_we_o) begin
            ram[arf_addr_o] <= arf_din_o;
        end
        rpipe[0] <= (arf_en_o && !arf_we_o) ? ram[arf_addr_o] : '0;
        for (int i = 1; i <= RD; i++) rpipe[i] <= rpipe[i-1];
    end
    assign arf_dout_i = rpipe[RD];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Round-robin reference: first valid requester after the last winner
    function automatic int exp_grant(logic [N-1:0] vv, int last);
        for (int i = 1; i <= N; i++) begin
            if (vv[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // One clock cycle: check grant, advance the model, check the ARF port
    task automatic step(output int dut_acc);
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = rst ? -1 : exp_grant(v, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", 64'(req_ready_o), 64'(exp_rdy));
        dut_acc = -1;
        for (int k = 0; k < N; k++) if (req_ready_o[k] === 1'b1 && v[k]) dut_acc = k;
        if (rst) begin
            q.delete();
            m_ptr = N - 1;
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
        end else if (g >= 0) begin
            m_ptr  = g;
            e_en   = 1'b1;
            e_we   = w[g];
            e_addr = a[g];
            e_din  = d[g];
            if (w[g]) mem[a[g]] = d[g];
            else q.push_back('{g, mem[a[g]], cyc + RD + 2});
        end else begin
            e_en = 1'b0;
            e_we = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("arf_en", 64'(arf_en_o), 64'(e_en));
        chk("arf_we", 64'(arf_we_o), 64'(e_we));
        chk("arf_addr", 64'(arf_addr_o), 64'(e_addr));
        chk("arf_din", 64'(arf_din_o), 64'(e_din));
    endtask

    task automatic do_reset(input int n);
        int t;
        rst = 1'b1;
        v = '1;
        for (int i = 0; i < n; i++) step(t);
        rst = 1'b0;
        v = '0;
    endtask

    task automatic idle(input int n);
        int t;
        v = '0;
        for (int i = 0; i < n; i++) step(t);
    endtask

    // Response monitor: pops the scoreboard whenever a strobe appears or is overdue
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rsp_valid_o !== '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("rsp_strobe", 64'(rsp_valid_o), 64'(1) << e.req);
                    chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 64'(rsp_valid_o), 64'(1) << e.req);
            end
        end
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; mon_en = 1'b0; ram_init = 1'b0;
        rst = 1'b1; v = '0; w = '0; m_ptr = N - 1;
        for (int k = 0; k < N; k++) begin a[k] = '0; d[k] = '0; end
        for (int i = 0; i < 32; i++) mem[i] = init_val(i);
        @(negedge clk);
        #1;
        do_reset(1);
        mon_en = 1'b1;
        do_reset(2);

        // Single read of preloaded address 4
        v = 2'b01; w = 2'b00; a[0] = 5'd4;
        step(acc); chk("single_grant", 64'(acc), 64'(0));
        idle(6);

        // Contention: alternating grants, no bubbles
        do_reset(1);
        v = 2'b11; w = 2'b00; a[0] = 5'd1; a[1] = 5'd2;
        for (int i = 0; i < 6; i++) begin
            step(acc); chk("contention_grant", 64'(acc), 64'(i % 2));
        end
        idle(6);

        // Write by req1 then read by req0 of the same address
        do_reset(1);
        v = 2'b10; w = 2'b10; a[1] = 5'd7; d[1] = 36'hA_BCDE_F012;
        step(acc); chk("raw_write_grant", 64'(acc), 64'(1));
        v = 2'b01; w = 2'b00; a[0] = 5'd7;
        step(acc); chk("raw_read_grant", 64'(acc), 64'(0));
        idle(6);

        // Pointer holds across idle cycles
        do_reset(1);
        v = 2'b10; w = 2'b00; a[1] = 5'd2;
        step(acc); chk("hold_first", 64'(acc), 64'(1));
        idle(5);
        v = 2'b11; a[0] = 5'd3;
        step(acc); chk("hold_after_idle", 64'(acc), 64'(0));
        v = 2'b10;
        step(acc); chk("hold_second", 64'(acc), 64'(1));
        idle(6);

        // Reset while a read is in flight
        do_reset(1);
        v = 2'b01; w = 2'b00; a[0] = 5'd3;
        step(acc); chk("midrst_accept", 64'(acc), 64'(0));
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        step(acc); chk("midrst_restart", 64'(acc), 64'(0));
        idle(6);

        // Requester 1 drops its request before being granted
        do_reset(1);
        v = 2'b11; w = 2'b10; a[0] = 5'd5; a[1] = 5'd6; d[1] = 36'h5_5555_5555;
        step(acc); chk("drop_first", 64'(acc), 64'(0));
        v = 2'b01;
        step(acc); chk("drop_req0_again", 64'(acc), 64'(0));
        idle(2);
        v = 2'b11; w = 2'b00;
        step(acc); chk("drop_ptr_req0", 64'(acc), 64'(1));
        idle(6);

        // Randomized traffic with hold-until-accept and occasional withdrawal
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if (v[k]) begin
                    if ($urandom_range(15, 0) == 0) v[k] = 1'b0;
                end else if ($urandom_range(1, 0) == 1) begin
                    v[k] = 1'b1;
                    w[k] = 1'($urandom_range(1, 0));
                    a[k] = 5'($urandom_range(7, 0));
                    d[k] = {4'($urandom_range(15, 0)), $urandom};
                end
            end
            if (i == 200) rst = 1'b1;
            step(acc);
            rst = 1'b0;
            if (acc >= 0) v[acc] = 1'b0;
        end
        idle(8);
        chk("scoreboard_drained", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
